// File: rtl/sb_pkg.sv
// sb_pkg: shared constants and FSM state type for the switch box array
package sb_pkg;
  localparam int BITS_PER_TRACK = 12;
  localparam int EN_LSB = 0;
  localparam int DIR_LSB = 6;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} sb_state_e;
endpackage

// File: rtl/bidir_buf.sv
// bidir_buf: enabled tristate buffer between a and b; dir=0 drives a->b, dir=1 drives b->a
module bidir_buf (
  input logic en,
  input logic dir,
  inout wire  a,
  inout wire  b
);
  assign b = (en && !dir) ? a : 1'bz;
  assign a = (en && dir) ? b : 1'bz;
endmodule

// File: rtl/sb_track.sv
// sb_track: one track's six disjoint buffers (l-u, u-r, r-d, d-l, l-r, u-d) from a 12-bit config slice
module sb_track
  import sb_pkg::*;
(
  input logic [BITS_PER_TRACK-1:0] cfg,
  inout wire                       l,
  inout wire                       u,
  inout wire                       r,
  inout wire                       d
);
  logic [5:0] en;
  logic [5:0] dir;
  assign en  = cfg[EN_LSB +: 6];
  assign dir = cfg[DIR_LSB +: 6];
  bidir_buf b0 (.en(en[0]), .dir(dir[0]), .a(l), .b(u));
  bidir_buf b1 (.en(en[1]), .dir(dir[1]), .a(u), .b(r));
  bidir_buf b2 (.en(en[2]), .dir(dir[2]), .a(r), .b(d));
  bidir_buf b3 (.en(en[3]), .dir(dir[3]), .a(d), .b(l));
  bidir_buf b4 (.en(en[4]), .dir(dir[4]), .a(l), .b(r));
  bidir_buf b5 (.en(en[5]), .dir(dir[5]), .a(u), .b(d));
endmodule

// File: rtl/switch_box_array.sv
// switch_box_array: W-track switch box with double-buffered scan config; SB_PARITY_CHECK_EN adds an even-parity frame bit
module switch_box_array
  import sb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire  [W-1:0] l,
  inout  wire  [W-1:0] u,
  inout  wire  [W-1:0] r,
  inout  wire  [W-1:0] d,
  input  logic         si,
  output logic         so,
  input  logic         cfg_en,
  input  logic         cfg_load,
  output logic         cfg_full,
  output logic         cfg_loaded,
  output logic         cfg_err
);
  localparam int CFG_LEN = W * BITS_PER_TRACK;
`ifdef SB_PARITY_CHECK_EN
  localparam int FRAME = CFG_LEN + 1;
`else
  localparam int FRAME = CFG_LEN;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME);
  logic [FRAME-1:0]   sr;
  logic [CFG_LEN-1:0] active;
  logic [CW-1:0]      cnt, cnt_inc, cnt_nx;
  sb_state_e          state, state_nx;
  logic               full_load, par_ok, accept;
`ifdef SB_PARITY_CHECK_EN
  assign par_ok = ~^sr;
`else
  assign par_ok = 1'b1;
`endif
  assign so       = sr[FRAME-1];
  assign cfg_full = (state == FULL);
  assign accept   = full_load && par_ok;
  // counter and state follow the shift; any load seen while FULL restarts the frame count
  always_comb begin
    full_load = cfg_load && (state == FULL);
    cnt_inc   = (cnt == FRAME_C) ? cnt : cnt + 1'b1;
    cnt_nx    = full_load ? CW'(cfg_en) : cfg_en ? cnt_inc : cnt;
    state_nx  = (cnt_nx == FRAME_C) ? FULL : (cnt_nx != '0) ? FILLING : EMPTY;
  end
  // shift chain, frame bookkeeping, atomic commit to the active register and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      active     <= '0;
      cnt        <= '0;
      state      <= EMPTY;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (cfg_en) sr <= {sr[FRAME-2:0], si};
      cnt        <= cnt_nx;
      state      <= state_nx;
      cfg_loaded <= accept;
      if (accept) active <= sr[FRAME-1 -: CFG_LEN];
      if (cfg_load && !accept) cfg_err <= 1'b1;
    end
  end
  for (genvar t = 0; t < W; t++) begin : g_trk
    sb_track trk (
      .cfg(active[t*BITS_PER_TRACK +: BITS_PER_TRACK]),
      .l(l[t]),
      .u(u[t]),
      .r(r[t]),
      .d(d[t])
    );
  end
endmodule

// File: tb/tb_switch_box_array.sv
// tb_switch_box_array: scoreboard bench for the scan chain, load handshake and track routing
module tb_switch_box_array;
  localparam int W = 4;
  localparam int CFG_LEN = W * 12;
`ifdef SB_PARITY_CHECK_EN
  localparam int FRAME = CFG_LEN + 1;
`else
  localparam int FRAME = CFG_LEN;
`endif
  logic clk = 1'b0, rst = 1'b1, si = 1'b0, cfg_en = 1'b0, cfg_load = 1'b0;
  logic so, cfg_full, cfg_loaded, cfg_err;
  wire [W-1:0] l, u, r, d;
  logic [W-1:0] l_oe = '0, u_oe = '0, r_oe = '0, d_oe = '0;
  int n_checks = 0, n_fail = 0;
  logic sbq[$];
  logic [CFG_LEN-1:0] fa, fb, fc;
  logic [FRAME-1:0] s;

  switch_box_array #(.W(W)) dut (
    .clk(clk), .rst(rst), .l(l), .u(u), .r(r), .d(d), .si(si), .so(so),
    .cfg_en(cfg_en), .cfg_load(cfg_load), .cfg_full(cfg_full),
    .cfg_loaded(cfg_loaded), .cfg_err(cfg_err)
  );

  for (genvar i = 0; i < W; i++) begin : g_pins
    pulldown pl (l[i]);
    pulldown pu (u[i]);
    pulldown pr (r[i]);
    pulldown pd (d[i]);
    assign l[i] = l_oe[i] ? 1'b1 : 1'bz;
    assign u[i] = u_oe[i] ? 1'b1 : 1'bz;
    assign r[i] = r_oe[i] ? 1'b1 : 1'bz;
    assign d[i] = d_oe[i] ? 1'b1 : 1'bz;
  end

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CFG_LEN-1:0] buf_cfg(input int t, input int k, input logic dir);
    logic [CFG_LEN-1:0] f;
    f = '0;
    f[12*t + k] = 1'b1;
    f[12*t + 6 + k] = dir;
    return f;
  endfunction

  function automatic logic [FRAME-1:0] stream(input logic [CFG_LEN-1:0] f, input logic flip);
`ifdef SB_PARITY_CHECK_EN
    return {f, (^f) ^ flip};
`else
    return f;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    repeat (FRAME - 1) sbq.push_back(1'b0);
  endtask

  task automatic shift_bit(input logic b, input logic ld);
    si = b;
    cfg_en = 1'b1;
    cfg_load = ld;
    sbq.push_back(b);
    @(posedge clk); #1;
    cfg_en = 1'b0;
    cfg_load = 1'b0;
    check("so", so, sbq.pop_front());
  endtask

  task automatic shift_frame(input logic [CFG_LEN-1:0] f, input logic flip);
    logic [FRAME-1:0] v;
    v = stream(f, flip);
    for (int i = FRAME - 1; i >= 0; i--) shift_bit(v[i], 1'b0);
  endtask

  task automatic load_pulse();
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic route(input string tag, input logic [W-1:0] dl, du, dr, dd,
                       input logic [W-1:0] el, eu, er, ed);
    l_oe = dl; u_oe = du; r_oe = dr; d_oe = dd;
    #1;
    check({tag, ".l"}, l, el | dl);
    check({tag, ".u"}, u, eu | du);
    check({tag, ".r"}, r, er | dr);
    check({tag, ".d"}, d, ed | dd);
    l_oe = '0; u_oe = '0; r_oe = '0; d_oe = '0;
    #1;
  endtask

  initial begin
    fa = buf_cfg(0, 0, 1'b0);
    fb = buf_cfg(2, 4, 1'b1) | buf_cfg(1, 5, 1'b0);
    fc = buf_cfg(3, 3, 1'b0);
    do_reset();
    check("rst_full", cfg_full, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_loaded", cfg_loaded, 1'b0);
    check("rst_so", so, 1'b0);
    route("rst_idle", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    route("rst_drv_l", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    s = stream(fa, 1'b0);
    for (int i = FRAME - 1; i >= 1; i--) shift_bit(s[i], 1'b0);
    check("a_full_early", cfg_full, 1'b0);
    shift_bit(s[0], 1'b0);
    check("a_full", cfg_full, 1'b1);
    check("a_loaded_pre", cfg_loaded, 1'b0);
    route("a_before_load", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    load_pulse();
    check("a_loaded", cfg_loaded, 1'b1);
    check("a_full_after", cfg_full, 1'b0);
    route("a_route", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    @(posedge clk); #1;
    check("a_loaded_drop", cfg_loaded, 1'b0);

    for (int i = 0; i < 20; i++) shift_bit(1'($urandom_range(1)), 1'b0);
    check("early_full", cfg_full, 1'b0);
    load_pulse();
    check("early_err", cfg_err, 1'b1);
    check("early_loaded", cfg_loaded, 1'b0);
    route("early_route", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);

    shift_frame(fb, 1'b0);
    check("b_full", cfg_full, 1'b1);
    route("b_pending", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
    load_pulse();
    check("b_loaded", cfg_loaded, 1'b1);
    check("b_err_sticky", cfg_err, 1'b1);
    route("b_r_to_l", 4'h0, 4'h0, 4'hF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
    route("b_u_to_d", 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
    route("b_l_dead", 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    shift_frame(fc, 1'b0);
    check("c_full", cfg_full, 1'b1);
    shift_bit(1'b1, 1'b1);
    check("c_loaded", cfg_loaded, 1'b1);
    check("c_full_after", cfg_full, 1'b0);
    route("c_d_to_l", 4'h0, 4'h0, 4'h0, 4'hF, 4'h8, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < FRAME - 2; i++) shift_bit(1'($urandom_range(1)), 1'b0);
    check("c_cnt_one", cfg_full, 1'b0);
    shift_bit(1'b0, 1'b0);
    check("c_cnt_full", cfg_full, 1'b1);

    for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b0);
    do_reset();
    check("rst2_err", cfg_err, 1'b0);
    check("rst2_full", cfg_full, 1'b0);
    check("rst2_so", so, 1'b0);
    route("rst2_route", 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

`ifdef SB_PARITY_CHECK_EN
    shift_frame(fa, 1'b1);
    check("p_bad_full", cfg_full, 1'b1);
    load_pulse();
    check("p_bad_err", cfg_err, 1'b1);
    check("p_bad_loaded", cfg_loaded, 1'b0);
    check("p_bad_state", cfg_full, 1'b0);
    route("p_bad_route", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    shift_frame(fa, 1'b0);
    load_pulse();
    check("p_ok_loaded", cfg_loaded, 1'b1);
    route("p_ok_route", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
